// File: rtl/abc_pipe_pkg.sv
// Shared types and constants for the A->B->C compute pipeline.
//   op_e           : per-stage arithmetic operation selector
//   stage_state_e  : stage FSM encoding (IDLE/BUSY/DONE)
//   A_ADD_K/C_SUB_K: stage A addend and stage C subtrahend
//   *_LAT_MAX      : legal upper latency bound per stage
package abc_pipe_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_MUL2, OP_SUB} op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} stage_state_e;

  localparam int unsigned A_ADD_K   = 100;
  localparam int unsigned C_SUB_K   = 50;

  localparam int unsigned A_LAT_MAX = 10;
  localparam int unsigned B_LAT_MAX = 5;
  localparam int unsigned C_LAT_MAX = 3;

  // Wide enough to hold the largest LAT-1 of any stage.
  localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/abc_compute_pipeline_stage.sv
// Single latency-contracted pipeline stage: FSM, down-counter, result register.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   accept       : operand taken this cycle (only meaningful while idle_c)
//   operand      : raw input value
//   hand_off     : result taken by the consumer this cycle (only meaningful while done_c)
//   idle_c       : stage in IDLE (combinational decode of state)
//   done_c       : stage in DONE (combinational decode of state)
//   result       : registered OP(operand), held until hand-off
module compose_stage
  import abc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 1,
  parameter op_e         OP    = OP_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [WIDTH-1:0] operand,
  input  logic             hand_off,
  output logic             idle_c,
  output logic             done_c,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_BUSY = 2'(S_BUSY);
  localparam logic [1:0] ST_DONE = 2'(S_DONE);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] result_nxt;

  // Stage arithmetic; all operations wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] x);
    case (OP)
      OP_ADD:  apply_op = x + WIDTH'(A_ADD_K);
      OP_MUL2: apply_op = {x[WIDTH-2:0], 1'b0};
      OP_SUB:  apply_op = x - WIDTH'(C_SUB_K);
      default: apply_op = x;
    endcase
  endfunction

  // State, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
    end
  end

  // Next-state logic. cnt holds the cycles still to spend in BUSY, so leaving
  // BUSY when cnt reaches 1 lands DONE exactly LAT cycles after accept.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    result_nxt = result;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          result_nxt = apply_op(operand);
          cnt_nxt    = CNT_W'(LAT - 1);
          state_nxt  = (LAT == 1) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (hand_off) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign idle_c = (state == ST_IDLE);
  assign done_c = (state == ST_DONE);

endmodule

// File: rtl/abc_compute_pipeline.sv
// Three-stage A->B->C pipeline: out = ((in + 100) * 2) - 50 mod 2^WIDTH.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_data/in_valid/in_ready        : system input handshake
//   out_data/out_valid/out_ready     : system output handshake
//   {a,b,c}_in / {a,b,c}_out         : stage tap data, zero when not valid
//   {a,b,c}_valid_in / _valid_out    : stage accept / hand-off pulses
module abc_compute_pipeline
  import abc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned A_LAT = 2,
  parameter int unsigned B_LAT = 1,
  parameter int unsigned C_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_in,
  output logic [WIDTH-1:0] c_out,
  output logic             a_valid_in,
  output logic             a_valid_out,
  output logic             b_valid_in,
  output logic             b_valid_out,
  output logic             c_valid_in,
  output logic             c_valid_out
);

  // Elaboration-time latency range checks.
  if (A_LAT == 0 || A_LAT > A_LAT_MAX) begin : g_bad_a_lat
    $error("abc_compute_pipeline: A_LAT out of range 1..%0d", A_LAT_MAX);
  end
  if (B_LAT == 0 || B_LAT > B_LAT_MAX) begin : g_bad_b_lat
    $error("abc_compute_pipeline: B_LAT out of range 1..%0d", B_LAT_MAX);
  end
  if (C_LAT == 0 || C_LAT > C_LAT_MAX) begin : g_bad_c_lat
    $error("abc_compute_pipeline: C_LAT out of range 1..%0d", C_LAT_MAX);
  end

  logic             run;
  logic             a_idle_c, a_done_c, b_idle_c, b_done_c, c_idle_c, c_done_c;
  logic [WIDTH-1:0] a_result, b_result, c_result;
  logic             a_acc, a_hand, b_acc, b_hand, c_acc, c_hand;
  logic             ab_full, bc_full;
  logic [WIDTH-1:0] ab_data, bc_data;

  // No transfer of any kind is allowed while reset is asserted.
  assign run = ~rst;

  // Handshake decode: a stage hands off only into an empty link, and a link
  // drains only into an idle stage, so a full link never overlaps a hand-off.
  assign in_ready  = a_idle_c & run;
  assign a_acc     = in_valid & in_ready;
  assign a_hand    = a_done_c & ~ab_full & run;
  assign b_acc     = ab_full & b_idle_c & run;
  assign b_hand    = b_done_c & ~bc_full & run;
  assign c_acc     = bc_full & c_idle_c & run;
  assign out_valid = c_done_c & run;
  assign c_hand    = out_valid & out_ready;
  assign out_data  = c_result;

  compose_stage #(.WIDTH(WIDTH), .LAT(A_LAT), .OP(OP_ADD)) u_stage_a (
    .clk(clk), .rst(rst), .accept(a_acc), .operand(in_data), .hand_off(a_hand),
    .idle_c(a_idle_c), .done_c(a_done_c), .result(a_result)
  );

  compose_stage #(.WIDTH(WIDTH), .LAT(B_LAT), .OP(OP_MUL2)) u_stage_b (
    .clk(clk), .rst(rst), .accept(b_acc), .operand(ab_data), .hand_off(b_hand),
    .idle_c(b_idle_c), .done_c(b_done_c), .result(b_result)
  );

  compose_stage #(.WIDTH(WIDTH), .LAT(C_LAT), .OP(OP_SUB)) u_stage_c (
    .clk(clk), .rst(rst), .accept(c_acc), .operand(bc_data), .hand_off(c_hand),
    .idle_c(c_idle_c), .done_c(c_done_c), .result(c_result)
  );

  // A->B one-entry link.
  always_ff @(posedge clk) begin
    if (rst) begin
      ab_full <= 1'b0;
      ab_data <= '0;
    end else if (a_hand) begin
      ab_full <= 1'b1;
      ab_data <= a_result;
    end else if (b_acc) begin
      ab_full <= 1'b0;
    end
  end

  // B->C one-entry link.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc_full <= 1'b0;
      bc_data <= '0;
    end else if (b_hand) begin
      bc_full <= 1'b1;
      bc_data <= b_result;
    end else if (c_acc) begin
      bc_full <= 1'b0;
    end
  end

  // Taps: pulse on the transfer cycle, data forced to zero otherwise.
  assign a_valid_in  = a_acc;
  assign a_valid_out = a_hand;
  assign b_valid_in  = b_acc;
  assign b_valid_out = b_hand;
  assign c_valid_in  = c_acc;
  assign c_valid_out = c_hand;

  assign a_in  = a_acc  ? in_data  : '0;
  assign a_out = a_hand ? a_result : '0;
  assign b_in  = b_acc  ? ab_data  : '0;
  assign b_out = b_hand ? b_result : '0;
  assign c_in  = c_acc  ? bc_data  : '0;
  assign c_out = c_hand ? c_result : '0;

endmodule
